// File: rtl/int_img_ctrl.sv
// int_img_ctrl: sequences integral-image calculation and raster-order
// window scanning for one frame at a time.
// Optional macro INT_IMG_CTRL_PERF_EN adds the frame_cycles counter output.
module int_img_ctrl #(
  parameter int unsigned WIDTH_LIMIT  = 10,
  parameter int unsigned HEIGHT_LIMIT = 10,
  parameter int unsigned WIN_SIZE     = 4,
  parameter int unsigned STEP         = 3,
  parameter int unsigned CALC_LAT     = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            img_valid,
  output logic                            img_ready,
  input  logic                            abort,
  output logic                            calc_enable,
  output logic                            int_img_valid,
  output logic                            win_valid,
  input  logic                            win_ready,
  output logic [$clog2(WIDTH_LIMIT)-1:0]  win_x,
  output logic [$clog2(HEIGHT_LIMIT)-1:0] win_y,
  output logic                            win_last,
  output logic                            frame_done
`ifdef INT_IMG_CTRL_PERF_EN
  ,
  output logic [31:0]                     frame_cycles
`endif
);

  localparam int unsigned XW    = $clog2(WIDTH_LIMIT);
  localparam int unsigned YW    = $clog2(HEIGHT_LIMIT);
  localparam int unsigned MAXWH = (WIDTH_LIMIT > HEIGHT_LIMIT) ? WIDTH_LIMIT : HEIGHT_LIMIT;
  localparam int unsigned MAXD  = (MAXWH > STEP) ? MAXWH : STEP;
  // Comparison width: one spare bit beyond the largest operand plus carry headroom
  localparam int unsigned CW    = $clog2(MAXD) + 2;
  localparam int unsigned CNTW  = $clog2(CALC_LAT) + 1;
  localparam int unsigned XMAX  = WIDTH_LIMIT - WIN_SIZE;
  localparam int unsigned YMAX  = HEIGHT_LIMIT - WIN_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_n;
  logic [CNTW-1:0] cnt_q, cnt_n;
  logic [XW-1:0]   x_n;
  logic [YW-1:0]   y_n;
  logic            img_ready_n;
  logic            calc_enable_n;
  logic            int_img_valid_n;
  logic            win_valid_n;
  logic            win_last_n;
  logic            frame_done_n;

  // True when stepping right from column x would leave the image
  function automatic logic x_wraps(input logic [XW-1:0] x);
    return (CW'(x) + CW'(STEP)) > CW'(XMAX);
  endfunction

  // True when stepping down from row y would leave the image
  function automatic logic y_wraps(input logic [YW-1:0] y);
    return (CW'(y) + CW'(STEP)) > CW'(YMAX);
  endfunction

  // Next-state, counter, coordinate and output decode
  always_comb begin
    state_n         = state_q;
    cnt_n           = cnt_q;
    x_n             = win_x;
    y_n             = win_y;
    img_ready_n     = 1'b0;
    calc_enable_n   = 1'b0;
    int_img_valid_n = 1'b0;
    win_valid_n     = 1'b0;
    win_last_n      = 1'b0;
    frame_done_n    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!abort && img_valid) begin
          state_n = CALC;
        end
      end
      CALC: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cnt_q == CNTW'(CALC_LAT - 1)) begin
          state_n = SCAN;
        end else begin
          cnt_n = cnt_q + CNTW'(1);
        end
      end
      SCAN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (win_ready) begin
          if (win_last) begin
            state_n = DONE;
          end else if (x_wraps(win_x)) begin
            x_n = '0;
            y_n = YW'(CW'(win_y) + CW'(STEP));
          end else begin
            x_n = XW'(CW'(win_x) + CW'(STEP));
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Coordinates and the latency counter only live inside their own phase
    if (state_n != SCAN) begin
      x_n = '0;
      y_n = '0;
    end
    if (state_n != CALC) begin
      cnt_n = '0;
    end

    img_ready_n     = (state_n == IDLE);
    calc_enable_n   = (state_n == CALC);
    int_img_valid_n = (state_n == SCAN) || (state_n == DONE);
    win_valid_n     = (state_n == SCAN);
    frame_done_n    = (state_n == DONE);
    win_last_n      = (state_n == SCAN) && x_wraps(x_n) && y_wraps(y_n);
  end

  // State, counter, coordinate and registered output update
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      win_x         <= '0;
      win_y         <= '0;
      img_ready     <= 1'b1;
      calc_enable   <= 1'b0;
      int_img_valid <= 1'b0;
      win_valid     <= 1'b0;
      win_last      <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      win_x         <= x_n;
      win_y         <= y_n;
      img_ready     <= img_ready_n;
      calc_enable   <= calc_enable_n;
      int_img_valid <= int_img_valid_n;
      win_valid     <= win_valid_n;
      win_last      <= win_last_n;
      frame_done    <= frame_done_n;
    end
  end

`ifdef INT_IMG_CTRL_PERF_EN
  logic [31:0] cyc_q, cyc_n;
  logic [31:0] frame_cycles_n;

  // Cycle count from accept; latched into frame_cycles on the done cycle
  always_comb begin
    cyc_n          = cyc_q;
    frame_cycles_n = frame_cycles;
    if (state_q == IDLE) begin
      cyc_n = (state_n == CALC) ? 32'd1 : 32'd0;
    end else begin
      cyc_n = cyc_q + 32'd1;
    end
    if (state_q == DONE) begin
      frame_cycles_n = cyc_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      cyc_q        <= '0;
      frame_cycles <= '0;
    end else begin
      cyc_q        <= cyc_n;
      frame_cycles <= frame_cycles_n;
    end
  end
`endif

endmodule

// File: doc/int_img_ctrl.md
INT_IMG_CTRL -- requirements
Module: int_img_ctrl

Interface
REQ-001 Parameter WIDTH_LIMIT, 10, image width in pixels; SHALL be >= WIN_SIZE.
REQ-002 Parameter HEIGHT_LIMIT, 10, image height in pixels; SHALL be >= WIN_SIZE.
REQ-003 Parameter WIN_SIZE, 4, detection window edge in pixels.
REQ-004 Parameter STEP, 3, window stride in pixels; SHALL be >= 1.
REQ-005 Parameter CALC_LAT, 2, number of enabled cycles int_img_calc needs to produce a stable output; SHALL be >= 1.
REQ-006 clock  in  1  single clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 img_valid  in  1  upstream frame is present on input_img.
REQ-009 img_ready  out  1  controller can accept a frame.
REQ-010 abort  in  1  abandon the current frame.
REQ-011 calc_enable  out  1  drives int_img_calc enable.
REQ-012 int_img_valid  out  1  output_img and output_img_sq are stable and valid.
REQ-013 win_valid  out  1  a window coordinate is offered.
REQ-014 win_ready  in  1  downstream classifier accepts the offered window.
REQ-015 win_x  out  $clog2(WIDTH_LIMIT)  window left column.
REQ-016 win_y  out  $clog2(HEIGHT_LIMIT)  window top row.
REQ-017 win_last  out  1  the offered window is the final window of the frame.
REQ-018 frame_done  out  1  single-cycle pulse when the frame is complete.

Function
REQ-019 FSM states SHALL be IDLE, CALC, SCAN and DONE.
REQ-020 IDLE: img_ready=1 and all other outputs are 0; img_valid=1 moves the FSM to CALC on the same edge (accept).
REQ-021 CALC: calc_enable=1 for exactly CALC_LAT consecutive cycles, counted by an internal counter, then the FSM moves to SCAN.
REQ-022 Upstream SHALL hold input_img stable from accept until frame_done; the controller SHALL NOT accept another frame before it returns to IDLE.
REQ-023 SCAN: int_img_valid=1 and win_valid=1; the first window is (0,0).
REQ-024 Handshake: a window transfers on a cycle where win_valid=1 and win_ready=1; win_x, win_y and win_last SHALL stay constant while win_valid=1 and win_ready=0.
REQ-025 Raster order: after each transfer, win_x increases by STEP; if win_x+STEP > WIDTH_LIMIT-WIN_SIZE, win_x wraps to 0 and win_y increases by STEP.
REQ-026 win_last=1 exactly when win_x+STEP > WIDTH_LIMIT-WIN_SIZE and win_y+STEP > HEIGHT_LIMIT-WIN_SIZE.
REQ-027 Comparisons SHALL use widths of at least $clog2(max(WIDTH_LIMIT,HEIGHT_LIMIT))+1 bits so that coordinates cannot overflow.
REQ-028 Transfer of the last window moves the FSM to DONE; DONE asserts frame_done=1 and int_img_valid=1 for one cycle, then returns to IDLE.
REQ-029 Window count per frame SHALL be (floor((WIDTH_LIMIT-WIN_SIZE)/STEP)+1) * (floor((HEIGHT_LIMIT-WIN_SIZE)/STEP)+1).
REQ-030 WIN_SIZE equal to both limits: the single window (0,0) has win_last=1.
REQ-031 abort=1 in any state other than IDLE returns the FSM to IDLE on the next edge with no frame_done pulse; in IDLE, abort has priority over img_valid and blocks accept that cycle.
REQ-032 abort=1 in the same cycle as the last window transfer: abort wins and no frame_done pulse occurs.

Reset
REQ-033 reset=0 at a rising edge SHALL force IDLE, clear all counters and coordinates, and drive img_ready=1 with every other output 0 from the following cycle, including when reset occurs mid-frame.

Configuration
REQ-034 Macro INT_IMG_CTRL_PERF_EN defined: add output frame_cycles (32 bits), which counts the cycles from accept to frame_done inclusive, updates when frame_done is pulsed, is held otherwise, and resets to 0. Macro undefined: the port and its counter are absent and all other behaviour is identical.

Verification (WIDTH_LIMIT=10, HEIGHT_LIMIT=10, WIN_SIZE=4, STEP=3, CALC_LAT=2)
REQ-035 img_valid pulsed with win_ready held at 1 -> calc_enable high for 2 cycles; 9 windows (0,0),(3,0),(6,0),(0,3)...(6,6); win_last only on (6,6); frame_done pulses on the next cycle.
REQ-036 win_ready toggled 1,0,0,1,... -> coordinates are held while stalled; no window is skipped or repeated; 9 transfers occur in total.
REQ-037 abort asserted during the fourth window -> IDLE on the next cycle, no frame_done; the next frame restarts at (0,0).
REQ-038 reset=0 during CALC -> the following cycle shows img_ready=1 and calc_enable=0.
REQ-039 img_valid=1 held during SCAN -> no second accept until after frame_done.
REQ-040 INT_IMG_CTRL_PERF_EN defined with win_ready held at 1 -> frame_cycles=13 after the frame (1 accept + 2 CALC + 9 SCAN + 1 DONE).
